// File: rtl/id_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : id_queue
// Purpose  : Decode-stage instruction queue. It buffers fetched instructions,
//            resolves branches and jumps at the head, keeps the branch delay
//            slot, and registers the issued instruction into the X stage.
// Revision : 1.0  initial release
// ============================================================================
module id_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc4,
  input  logic [31:0]              in_ir,
  input  logic                     stall_D,
  input  logic                     flush,
  output logic [4:0]               rs_addr,
  output logic [4:0]               rt_addr,
  input  logic [31:0]              rs_val,
  input  logic [31:0]              rt_val,
  output logic                     redirect_valid,
  output logic [31:0]              NPC_D,
  output logic                     out_valid,
  output logic [31:0]              PCInc4_X,
  output logic [31:0]              IR_X,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Queue storage and circular pointers
  logic [31:0]   ir_mem  [DEPTH];
  logic [31:0]   pc4_mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  // Head view; forced to zero when empty so operand addresses read 0
  logic          not_empty;
  logic [31:0]   head_ir;
  logic [31:0]   head_pc4;
  logic [5:0]    op;
  logic [4:0]    rt_f;
  logic [5:0]    funct;
  logic [31:0]   br_target;
  logic [31:0]   jmp_target;

  // Decode results
  logic          is_ctrl;
  logic          taken;
  logic [31:0]   target;
  logic          slot_ok;
  logic          issue;
  logic          push;
  logic          mem_we;

  assign not_empty  = (count != '0);
  assign head_ir    = not_empty ? ir_mem[head]  : 32'd0;
  assign head_pc4   = not_empty ? pc4_mem[head] : 32'd0;
  assign op         = head_ir[31:26];
  assign rt_f       = head_ir[20:16];
  assign funct      = head_ir[5:0];
  assign rs_addr    = head_ir[25:21];
  assign rt_addr    = head_ir[20:16];
  assign br_target  = head_pc4 + {{14{head_ir[15]}}, head_ir[15:0], 2'b00};
  assign jmp_target = {head_pc4[31:28], head_ir[25:0], 2'b00};

  assign in_ready   = (count < CW'(DEPTH));

  // Classify the head instruction and resolve its direction and target
  always_comb begin
    is_ctrl = 1'b0;
    taken   = 1'b0;
    target  = 32'd0;
    case (op)
      6'b000100: begin  // beq
        is_ctrl = 1'b1;
        taken   = (rs_val == rt_val);
        target  = br_target;
      end
      6'b000101: begin  // bne
        is_ctrl = 1'b1;
        taken   = (rs_val != rt_val);
        target  = br_target;
      end
      6'b000110: begin  // blez
        is_ctrl = 1'b1;
        taken   = ($signed(rs_val) <= 32'sd0);
        target  = br_target;
      end
      6'b000111: begin  // bgtz
        is_ctrl = 1'b1;
        taken   = ($signed(rs_val) > 32'sd0);
        target  = br_target;
      end
      6'b000001: begin  // regimm: only bltz / bgez are control transfers here
        if (rt_f == 5'd0) begin
          is_ctrl = 1'b1;
          taken   = rs_val[31];
          target  = br_target;
        end else if (rt_f == 5'd1) begin
          is_ctrl = 1'b1;
          taken   = !rs_val[31];
          target  = br_target;
        end
      end
      6'b000010, 6'b000011: begin  // j, jal
        is_ctrl = 1'b1;
        taken   = 1'b1;
        target  = jmp_target;
      end
      6'b000000: begin  // jr, jalr
        if (funct == 6'b001000 || funct == 6'b001001) begin
          is_ctrl = 1'b1;
          taken   = 1'b1;
          target  = rs_val;
        end
      end
      default: ;
    endcase
  end

  // A control transfer may only leave once its delay slot is present or arriving
  assign slot_ok        = (count >= CW'(2)) || ((count == CW'(1)) && in_valid);
  assign issue          = not_empty && !stall_D && !flush && (!is_ctrl || slot_ok);
  assign redirect_valid = issue && is_ctrl && taken;
  assign NPC_D          = redirect_valid ? target : 32'd0;
  assign push           = in_valid && in_ready && !flush;
  // On a redirect the incoming word is written only when it is the delay slot
  assign mem_we         = rst_n && push && (!redirect_valid || (count == CW'(1)));

  // Storage write port; contents need no reset since count gates visibility
  always_ff @(posedge clk) begin
    if (mem_we) begin
      ir_mem[tail]  <= in_ir;
      pc4_mem[tail] <= in_pc4;
    end
  end

  // Pointer and occupancy update; a redirect collapses the queue to the slot
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (redirect_valid) begin
      head  <= head + AW'(1);
      tail  <= head + AW'(2);
      count <= CW'(1);
    end else begin
      if (push) tail <= tail + AW'(1);
      if (issue) head <= head + AW'(1);
      count <= count + CW'(push) - CW'(issue);
    end
  end

  // X-stage register: load on issue, hold on stall, otherwise insert a bubble
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      out_valid <= 1'b0;
      PCInc4_X  <= 32'd0;
      IR_X      <= 32'd0;
    end else if (issue) begin
      out_valid <= 1'b1;
      PCInc4_X  <= head_pc4;
      IR_X      <= head_ir;
    end else if (!stall_D) begin
      out_valid <= 1'b0;
      PCInc4_X  <= 32'd0;
      IR_X      <= 32'd0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_id_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_id_queue
// Purpose  : Self-checking bench for id_queue: branch decode vector table,
//            FIFO ordering scoreboard and multi-cycle corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_id_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] SLOT  = 32'h01095020;
  localparam logic [31:0] EXTRA = 32'h014B6022;
  localparam logic [31:0] ALU0  = 32'h00221820;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, stall_D, flush;
  logic [31:0] in_pc4, in_ir, rs_val, rt_val, NPC_D, PCInc4_X, IR_X;
  logic [4:0]  rs_addr, rt_addr;
  logic        redirect_valid, out_valid;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  typedef struct { logic [31:0] pc4; logic [31:0] ir; } entry_t;
  entry_t sb[$];

  typedef struct {
    logic [31:0] pc4; logic [31:0] ir; logic [31:0] rs; logic [31:0] rt;
    logic        redir; logic [31:0] npc;
  } vec_t;
  localparam int NV = 18;
  vec_t vt[NV];

  id_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc4(in_pc4), .in_ir(in_ir), .stall_D(stall_D), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_val(rs_val), .rt_val(rt_val),
    .redirect_valid(redirect_valid), .NPC_D(NPC_D), .out_valid(out_valid),
    .PCInc4_X(PCInc4_X), .IR_X(IR_X), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_held(input logic [31:0] pc4, input logic [31:0] ir);
    stall_D  = 1'b1;
    in_valid = 1'b1;
    in_pc4   = pc4;
    in_ir    = ir;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_flush;
    flush    = 1'b1;
    in_valid = 1'b0;
    tick();
    flush    = 1'b0;
    sb.delete();
  endtask

  task automatic sb_check(input string name);
    entry_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got issue with empty scoreboard want none", name);
    end else begin
      e = sb.pop_front();
      chk({name, "_valid"}, 32'(out_valid), 32'd1);
      chk({name, "_ir"}, IR_X, e.ir);
      chk({name, "_pc4"}, PCInc4_X, e.pc4);
    end
  endtask

  initial begin
    vt[0]  = '{32'h100,      32'h10220003, 32'd5,        32'd5, 1'b1, 32'h0000010C}; // beq taken
    vt[1]  = '{32'h100,      32'h10220003, 32'd5,        32'd6, 1'b0, 32'h0};        // beq not taken
    vt[2]  = '{32'h100,      32'h1422FFFF, 32'd7,        32'd7, 1'b0, 32'h0};        // bne not taken
    vt[3]  = '{32'h100,      32'h1422FFFF, 32'd7,        32'd8, 1'b1, 32'h000000FC}; // bne back
    vt[4]  = '{32'h100,      32'h18600010, 32'd0,        32'd0, 1'b1, 32'h00000140}; // blez 0
    vt[5]  = '{32'h100,      32'h18600010, 32'd1,        32'd0, 1'b0, 32'h0};        // blez 1
    vt[6]  = '{32'h100,      32'h1C800001, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h0};        // bgtz -1
    vt[7]  = '{32'h100,      32'h1C800001, 32'd7,        32'd0, 1'b1, 32'h00000104}; // bgtz 7
    vt[8]  = '{32'h100,      32'h04A00002, 32'h80000000, 32'd0, 1'b1, 32'h00000108}; // bltz min
    vt[9]  = '{32'h100,      32'h04A00002, 32'd0,        32'd0, 1'b0, 32'h0};        // bltz 0
    vt[10] = '{32'h100,      32'h04C18000, 32'd0,        32'd0, 1'b1, 32'hFFFE0100}; // bgez 0
    vt[11] = '{32'h100,      32'h04C18000, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h0};        // bgez -1
    vt[12] = '{32'h90000100, 32'h08100040, 32'd0,        32'd0, 1'b1, 32'h90400100}; // j
    vt[13] = '{32'h10000004, 32'h0FFFFFFF, 32'd0,        32'd0, 1'b1, 32'h1FFFFFFC}; // jal
    vt[14] = '{32'h100,      32'h01000008, 32'h00400020, 32'd0, 1'b1, 32'h00400020}; // jr
    vt[15] = '{32'h100,      32'h0120F809, 32'h00001234, 32'd0, 1'b1, 32'h00001234}; // jalr
    vt[16] = '{32'h100,      32'hFC221234, 32'd0,        32'd0, 1'b0, 32'h0};        // unknown op
    vt[17] = '{32'h100,      32'h04B00002, 32'h80000000, 32'd0, 1'b0, 32'h0};        // bltzal: not ctrl

    rst_n = 1'b0; in_valid = 1'b0; stall_D = 1'b0; flush = 1'b0;
    in_pc4 = 32'd0; in_ir = 32'd0; rs_val = 32'd0; rt_val = 32'd0;

    // Reset state
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_ir_x", IR_X, 32'd0);
    chk("rst_pc4_x", PCInc4_X, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_redirect", 32'(redirect_valid), 32'd0);
    chk("rst_rs_addr", 32'(rs_addr), 32'd0);

    // Fill under stall, full backpressure, then in-order drain
    stall_D = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_pc4   = 32'h200 + 32'(4 * i);
      in_ir    = ALU0 + 32'(i);
      sb.push_back('{in_pc4, in_ir});
      tick();
    end
    in_ir = 32'hDEADBEEF;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    tick();
    chk("full_count_hold", 32'(count), 32'd4);
    chk("full_stall_valid", 32'(out_valid), 32'd0);
    in_valid = 1'b0;
    stall_D  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      sb_check("drain");
      chk("drain_count", 32'(count), 32'(3 - i));
    end
    tick();
    chk("bubble_valid", 32'(out_valid), 32'd0);
    chk("bubble_ir", IR_X, 32'd0);
    chk("bubble_pc4", PCInc4_X, 32'd0);

    // Control-transfer decode table: ctrl head, delay slot, one younger entry
    for (int i = 0; i < NV; i++) begin
      do_flush();
      push_held(vt[i].pc4, vt[i].ir);
      sb.push_back('{vt[i].pc4, vt[i].ir});
      push_held(vt[i].pc4 + 32'd4, SLOT);
      sb.push_back('{vt[i].pc4 + 32'd4, SLOT});
      push_held(vt[i].pc4 + 32'd8, EXTRA);
      sb.push_back('{vt[i].pc4 + 32'd8, EXTRA});
      stall_D = 1'b0;
      rs_val  = vt[i].rs;
      rt_val  = vt[i].rt;
      #1;
      chk($sformatf("v%0d_redirect", i), 32'(redirect_valid), 32'(vt[i].redir));
      chk($sformatf("v%0d_npc", i), NPC_D, vt[i].npc);
      chk($sformatf("v%0d_rs_addr", i), 32'(rs_addr), 32'(vt[i].ir[25:21]));
      tick();
      sb_check($sformatf("v%0d_head", i));
      chk($sformatf("v%0d_count", i), 32'(count), vt[i].redir ? 32'd1 : 32'd2);
      if (vt[i].redir) void'(sb.pop_back());
      tick();
      sb_check($sformatf("v%0d_slot", i));
    end

    // Lone jump waits for its delay slot, then issues with it arriving
    do_flush();
    push_held(32'h400, 32'h08000100);
    stall_D = 1'b0;
    #1;
    chk("jwait_redirect", 32'(redirect_valid), 32'd0);
    tick();
    chk("jwait_valid", 32'(out_valid), 32'd0);
    chk("jwait_ir", IR_X, 32'd0);
    chk("jwait_count", 32'(count), 32'd1);
    in_valid = 1'b1;
    in_pc4   = 32'h404;
    in_ir    = SLOT;
    #1;
    chk("jgo_redirect", 32'(redirect_valid), 32'd1);
    chk("jgo_npc", NPC_D, 32'h00000400);
    tick();
    in_valid = 1'b0;
    chk("jgo_ir", IR_X, 32'h08000100);
    chk("jgo_count", 32'(count), 32'd1);
    tick();
    chk("jslot_ir", IR_X, SLOT);
    chk("jslot_pc4", PCInc4_X, 32'h404);
    chk("jslot_count", 32'(count), 32'd0);

    // jr with simultaneous flush: flush wins
    do_flush();
    stall_D = 1'b0; in_valid = 1'b1; in_pc4 = 32'h500; in_ir = ALU0;
    tick();
    in_pc4 = 32'h504; in_ir = 32'h01000008;
    tick();
    push_held(32'h508, SLOT);
    chk("jrf_pre_valid", 32'(out_valid), 32'd1);
    stall_D = 1'b0;
    rs_val  = 32'h00400020;
    #1;
    chk("jrf_npc", NPC_D, 32'h00400020);
    flush = 1'b1;
    #1;
    chk("jrf_redirect", 32'(redirect_valid), 32'd0);
    chk("jrf_npc_zero", NPC_D, 32'd0);
    tick();
    flush = 1'b0;
    chk("jrf_count", 32'(count), 32'd0);
    chk("jrf_valid", 32'(out_valid), 32'd0);
    chk("jrf_ir", IR_X, 32'd0);

    // Latency, push+pop same cycle, then reset mid-operation
    sb.delete();
    stall_D = 1'b0; in_valid = 1'b1; in_pc4 = 32'h600; in_ir = ALU0;
    sb.push_back('{in_pc4, in_ir});
    tick();
    chk("lat_count", 32'(count), 32'd1);
    chk("lat_valid", 32'(out_valid), 32'd0);
    in_pc4 = 32'h604; in_ir = ALU0 + 32'd1;
    tick();
    sb_check("lat");
    chk("pp_count", 32'(count), 32'd1);
    stall_D = 1'b1;
    in_pc4 = 32'h608; in_ir = ALU0 + 32'd2;
    tick();
    in_pc4 = 32'h60C; in_ir = ALU0 + 32'd3;
    tick();
    in_valid = 1'b0;
    chk("prerst_count", 32'(count), 32'd3);
    chk("prerst_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0; stall_D = 1'b0; in_valid = 1'b1; flush = 1'b1;
    tick();
    rst_n = 1'b1; in_valid = 1'b0; flush = 1'b0;
    chk("mrst_count", 32'(count), 32'd0);
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_ir", IR_X, 32'd0);
    chk("mrst_in_ready", 32'(in_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
